// File: rtl/vga_scan_timing.sv
// Raster timing generator: pixel-clock enable, h/v scan counters, VGA sync/blank,
// and a pixel-paced delay line that aligns sync with downstream ROM read latency.
module vga_scan_timing #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CLK_DIV    = 2,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d_nxt;
    logic             pce_q, frame_q, frame_d;
    logic             tick;

    // tick marks the edge on which the counters step; pixel_ce is its registered copy,
    // so pixel_ce is high in the same cycle the new DrawX/DrawY becomes visible.
    assign tick = enable && (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q;
        if (!enable || tick) div_d = '0;
        else                 div_d = div_q + DIV_W'(1);
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == 10'(H_TOTAL - 1)) begin
                x_d = '0;
                if (y_q == 10'(V_TOTAL - 1)) y_d = '0;
                else                         y_d = y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Sync/blank are derived from the next counter values so they register
    // in lockstep with DrawX/DrawY.
    always_comb begin
        hsync_d     = !((x_d >= 10'(HS_START)) && (x_d < 10'(HS_END)));
        vsync_d     = !((y_d >= 10'(VS_START)) && (y_d < 10'(VS_END)));
        blank_d_nxt = (x_d < 10'(H_VISIBLE)) && (y_d < 10'(V_VISIBLE));
        frame_d     = tick && (x_d == 10'd0) && (y_d == 10'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pce_q   <= 1'b0;
            frame_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pce_q   <= tick;
            frame_q <= frame_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d_nxt;
        end
    end

    assign pixel_ce    = pce_q;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = hsync_q;
    assign vs          = vsync_q;
    assign blank       = blank_q;
    assign frame_start = frame_q;

    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign hs_d    = hsync_q;
            assign vs_d    = vsync_q;
            assign blank_d = blank_q;
        end else begin : g_dly
            // Each entry is {hs, vs, blank}; resets to idle sync with blank deasserted.
            logic [2:0] dly_q [SYNC_DELAY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_DELAY; i++) dly_q[i] <= 3'b110;
                end else if (tick) begin
                    dly_q[0] <= {hsync_q, vsync_q, blank_q};
                    for (int i = 1; i < SYNC_DELAY; i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign hs_d    = dly_q[SYNC_DELAY-1][2];
            assign vs_d    = dly_q[SYNC_DELAY-1][1];
            assign blank_d = dly_q[SYNC_DELAY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench: default 640x480 timing instance plus a small-geometry
// pass-through instance (CLK_DIV=1, SYNC_DELAY=0) for whole-frame behaviour.
module tb_vga_scan_timing;

    logic clk;
    logic rst_n, en, rst2_n, en2;

    logic       pce, hs, vs, bl, fs, hsd, vsd, bld;
    logic [9:0] x, y;
    logic       pce2, hs2, vs2, bl2, fs2, hsd2, vsd2, bld2;
    logic [9:0] x2, y2;

    int vectors = 0;
    int miscompares = 0;

    vga_scan_timing u_dut (
        .clk(clk), .reset_n(rst_n), .enable(en),
        .pixel_ce(pce), .DrawX(x), .DrawY(y), .hs(hs), .vs(vs), .blank(bl),
        .frame_start(fs), .hs_d(hsd), .vs_d(vsd), .blank_d(bld)
    );

    // 32 x 17 raster: hsync x 24..29, vsync y 12..13, visible x<20, y<10
    vga_scan_timing #(
        .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(2),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(1), .SYNC_DELAY(0)
    ) u_small (
        .clk(clk), .reset_n(rst2_n), .enable(en2),
        .pixel_ce(pce2), .DrawX(x2), .DrawY(y2), .hs(hs2), .vs(vs2), .blank(bl2),
        .frame_start(fs2), .hs_d(hsd2), .vs_d(vsd2), .blank_d(bld2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic big_hs(input int px);
        return !(px >= 656 && px < 752);
    endfunction

    function automatic logic big_blank(input int px, input int ln);
        return (px < 640) && (ln < 480);
    endfunction

    initial begin
        int hs_low, n, sx, sy, fs_cnt, fs_first, fs_last;
        rst_n = 1'b0; en = 1'b1; rst2_n = 1'b0; en2 = 1'b1;

        #12;
        chk("rst_ce", pce, 0);   chk("rst_x", x, 0);     chk("rst_y", y, 0);
        chk("rst_hs", hs, 1);    chk("rst_vs", vs, 1);   chk("rst_blank", bl, 1);
        chk("rst_fs", fs, 0);    chk("rst_hs_d", hsd, 1); chk("rst_vs_d", vsd, 1);
        chk("rst_blank_d", bld, 0);

        // reset release: pixel_ce on clk 2,4,..., DrawX steps with it
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); chk("clk1_ce", pce, 0); chk("clk1_x", x, 0); chk("clk1_blank_d", bld, 0);
        chk("clk1_fs", fs, 0);
        @(negedge clk); chk("clk2_ce", pce, 1); chk("clk2_x", x, 1); chk("clk2_blank", bl, 1);
        chk("clk2_hs", hs, 1); chk("clk2_vs", vs, 1); chk("clk2_blank_d", bld, 1); chk("clk2_hs_d", hsd, 1);
        @(negedge clk); chk("clk3_ce", pce, 0); chk("clk3_x", x, 1);
        @(negedge clk); chk("clk4_ce", pce, 1); chk("clk4_x", x, 2);

        // run to (799,10), then line wrap
        clk_n(2 * (10 * 800 + 799 - 2));
        chk("eol_x", x, 799); chk("eol_y", y, 10); chk("eol_ce", pce, 1);
        clk_n(2);
        chk("wrap_x", x, 0); chk("wrap_y", y, 11); chk("wrap_fs", fs, 0);

        // one full line of pixels, sync/blank and delayed copies
        hs_low = 0;
        for (int k = 0; k < 800; k++) begin
            chk("line_x", x, k);
            chk("line_y", y, 11);
            chk("line_hs", hs, big_hs(k));
            chk("line_blank", bl, big_blank(k, 11));
            chk("line_hs_d", hsd, (k == 0) ? 1'b1 : big_hs(k - 1));
            chk("line_blank_d", bld, (k == 0) ? 1'b0 : big_blank(k - 1, 11));
            chk("line_vs", vs, 1);
            if (hs === 1'b0) hs_low++;
            clk_n(2);
        end
        chk("hs_low_count", hs_low, 96);
        chk("line_end_x", x, 0); chk("line_end_y", y, 12);

        // enable freeze at DrawX=100
        clk_n(200);
        chk("pre_freeze_x", x, 100);
        en = 1'b0;
        clk_n(37);
        chk("freeze_x", x, 100); chk("freeze_ce", pce, 0); chk("freeze_y", y, 12);
        en = 1'b1;
        clk_n(1); chk("resume1_x", x, 100); chk("resume1_ce", pce, 0);
        clk_n(1); chk("resume2_x", x, 101); chk("resume2_ce", pce, 1);

        // async reset between edges returns everything, including the delay line
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("mrst_x", x, 0); chk("mrst_y", y, 0); chk("mrst_ce", pce, 0);
        chk("mrst_hs", hs, 1); chk("mrst_vs", vs, 1); chk("mrst_blank", bl, 1);
        chk("mrst_hs_d", hsd, 1); chk("mrst_vs_d", vsd, 1); chk("mrst_blank_d", bld, 0);
        chk("mrst_fs", fs, 0);

        // small instance: pixel_ce every clk, pass-through delay, two frame wraps
        @(negedge clk); rst2_n = 1'b1;
        fs_cnt = 0; fs_first = 0; fs_last = 0;
        for (n = 1; n <= 1255; n++) begin
            @(negedge clk);
            sx = n % 32;
            sy = (n / 32) % 17;
            chk("sm_ce", pce2, 1);
            chk("sm_x", x2, sx);
            chk("sm_y", y2, sy);
            chk("sm_hs", hs2, !(sx >= 24 && sx < 30));
            chk("sm_vs", vs2, !(sy >= 12 && sy < 14));
            chk("sm_blank", bl2, (sx < 20) && (sy < 10));
            chk("sm_hs_d", hsd2, !(sx >= 24 && sx < 30));
            chk("sm_vs_d", vsd2, !(sy >= 12 && sy < 14));
            chk("sm_blank_d", bld2, (sx < 20) && (sy < 10));
            chk("sm_fs", fs2, (n % 544) == 0);
            if (fs2 === 1'b1) begin
                if (fs_cnt == 0) fs_first = n;
                fs_last = n;
                fs_cnt++;
            end
        end
        chk("sm_fs_count", fs_cnt, 2);
        chk("sm_fs_gap", fs_last - fs_first, 544);

        // mid-frame reset at (7,5) on the small instance, then restart from origin
        @(posedge clk); #2 rst2_n = 1'b0; #1;
        chk("srst_x", x2, 0); chk("srst_y", y2, 0); chk("srst_ce", pce2, 0);
        chk("srst_hs", hs2, 1); chk("srst_vs", vs2, 1); chk("srst_blank", bl2, 1);
        chk("srst_fs", fs2, 0);
        @(negedge clk); rst2_n = 1'b1;
        @(negedge clk); chk("srestart_x", x2, 1); chk("srestart_y", y2, 0); chk("srestart_ce", pce2, 1);
        chk("srestart_fs", fs2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
